// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, registered falling-edge detect, mid-bit sampling FSM.
// Optional `define UART_RX_MAJORITY_EN: every sample point uses the 2-of-3 majority of the last three synchronized values.
module uart_rx #(
    parameter int CLK_FREQ  = 80_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_rx_busy,
    output logic [1:0] o_state_debug
);

    localparam int BIT_TIME = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF     = BIT_TIME / 2;
    localparam int CNT_W    = $clog2(BIT_TIME) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TIME - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        READ_DATA = 2'd2,
        STOP      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             sync1_q, sync2_q, prev_q, fall_q;
    logic             fall_d;
    logic             sample_bit;

`ifdef UART_RX_MAJORITY_EN
    logic prev2_q;

    assign sample_bit = (sync2_q & prev_q) | (sync2_q & prev2_q) | (prev_q & prev2_q);
`else
    assign sample_bit = sync2_q;
`endif

    // Edge flag is registered so the FSM sees a single clean start event even when IDLE is re-entered.
    assign fall_d = prev_q & ~sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = sample_bit ? IDLE : READ_DATA;
                end
            end
            READ_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {sample_bit, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sample_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            fall_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            prev2_q   <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            sync1_q   <= i_rx;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            fall_q    <= fall_d;
`ifdef UART_RX_MAJORITY_EN
            prev2_q   <= prev_q;
`endif
        end
    end

    assign o_data        = data_q;
    assign o_rx_valid    = valid_q;
    assign o_frame_err   = ferr_q;
    assign o_rx_busy     = (state_q != IDLE);
    assign o_state_debug = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (694-cycle bits, half point 347).
module tb_uart_rx;

    localparam int BT      = 694;
    localparam int HALF    = 347;
    localparam int LATENCY = 3 + HALF + 9 * BT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;
    logic [1:0] st;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx         (rx),
        .o_data       (data),
        .o_rx_valid   (valid),
        .o_frame_err  (ferr),
        .o_rx_busy    (busy),
        .o_state_debug(st)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts, logs and width/overlap violations.
    int         vcnt = 0;
    int         fcnt = 0;
    int         overlap = 0;
    int         wide = 0;
    int         last_v_cyc = 0;
    logic [7:0] vlog [0:15];
    logic       v_d = 1'b0;
    logic       f_d = 1'b0;

    always @(negedge clk) begin
        if (valid) begin
            if (vcnt < 16) vlog[vcnt] <= data;
            vcnt       <= vcnt + 1;
            last_v_cyc <= cyc;
        end
        if (ferr) fcnt <= fcnt + 1;
        if (valid && ferr) overlap <= overlap + 1;
        if ((valid && v_d) || (ferr && f_d)) wide <= wide + 1;
        v_d <= valid;
        f_d <= ferr;
    end

    // Drives one 8N1 frame. spike_off >= 0 inverts one cycle inside every data bit;
    // abort_bit >= 0 returns mid-way through that data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int spike_off, input int abort_bit, output int e0);
        logic val;
        e0 = 0;
        for (int j = 0; j < 10; j++) begin
            val = (j == 0) ? 1'b0 : (j == 9) ? stop_bit : b[j-1];
            for (int c = 0; c < BT; c++) begin
                @(negedge clk);
                if (j == 0 && c == 0) e0 = cyc + 1;
                if (abort_bit >= 0 && j == abort_bit + 1 && c == 300) return;
                rx = (spike_off >= 0 && j >= 1 && j <= 8 && c == spike_off) ? ~val : val;
            end
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", st); end
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_single_byte();
        int e0;
        int v0 = vcnt;
        int f0 = fcnt;
        send_frame(8'hA5, 1'b1, -1, -1, e0);
        idle(20);
        checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL a5_count got=%0d exp=%0d", vcnt - v0, 1); end
        checks++; if (vlog[v0] !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", vlog[v0]); end
        checks++; if (last_v_cyc - e0 !== LATENCY) begin errors++; $display("FAIL a5_latency got=%0d exp=%0d", last_v_cyc - e0, LATENCY); end
        checks++; if (fcnt !== f0) begin errors++; $display("FAIL a5_ferr got=%0d exp=%0d", fcnt, f0); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL a5_hold got=%h exp=a5", data); end
    endtask

    task automatic test_back_to_back();
        int e0;
        int v0 = vcnt;
        logic [7:0] exp_b [0:2];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h5A;
        for (int k = 0; k < 3; k++) send_frame(exp_b[k], 1'b1, -1, -1, e0);
        idle(20);
        checks++; if (vcnt !== v0 + 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", vcnt - v0); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vlog[v0+k] !== exp_b[k]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", k, vlog[v0+k], exp_b[k]); end
        end
    endtask

    task automatic test_frame_error();
        int e0;
        int v0 = vcnt;
        int f0 = fcnt;
        send_frame(8'h3C, 1'b0, -1, -1, e0);
        idle(200);
        checks++; if (fcnt !== f0 + 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", fcnt - f0); end
        checks++; if (vcnt !== v0) begin errors++; $display("FAIL ferr_novalid got=%0d exp=0", vcnt - v0); end
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL ferr_hold got=%h exp=5a", data); end
        send_frame(8'h81, 1'b1, -1, -1, e0);
        idle(20);
        checks++; if (vcnt !== v0 + 1 || vlog[v0] !== 8'h81) begin errors++; $display("FAIL after_ferr got=%h exp=81", vlog[v0]); end
    endtask

    task automatic test_glitch();
        int v0 = vcnt;
        int f0 = fcnt;
        rx = 1'b0;
        repeat (50) @(negedge clk);
        checks++; if (st !== 2'd1) begin errors++; $display("FAIL glitch_start got=%0d exp=1", st); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got=%b exp=1", busy); end
        repeat (50) @(negedge clk);
        idle(500);
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL glitch_idle got=%0d exp=0", st); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_unbusy got=%b exp=0", busy); end
        checks++; if (vcnt !== v0 || fcnt !== f0) begin errors++; $display("FAIL glitch_pulses got=%0d/%0d exp=0/0", vcnt - v0, fcnt - f0); end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        int v0 = vcnt;
        int f0 = fcnt;
        send_frame(8'h77, 1'b1, -1, 4, e0);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        checks++; if (data !== 8'h00 || valid !== 1'b0 || ferr !== 1'b0) begin
            errors++; $display("FAIL midrst_out got=%h/%b/%b exp=00/0/0", data, valid, ferr); end
        checks++; if (st !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state got=%0d/%b exp=0/0", st, busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2000);
        checks++; if (vcnt !== v0 || fcnt !== f0) begin errors++; $display("FAIL midrst_pulses got=%0d/%0d exp=0/0", vcnt - v0, fcnt - f0); end
        send_frame(8'h12, 1'b1, -1, -1, e0);
        idle(20);
        checks++; if (vcnt !== v0 + 1 || data !== 8'h12) begin errors++; $display("FAIL after_rst got=%h exp=12", data); end
    endtask

    task automatic test_majority();
        int e0;
        int v0 = vcnt;
        logic [7:0] exp_v;
`ifdef UART_RX_MAJORITY_EN
        exp_v = 8'hC3;
`else
        exp_v = 8'h3C;
`endif
        // Spike lands on the cycle whose sample reaches the FSM exactly at each data sample point.
        send_frame(8'hC3, 1'b1, HALF + 1, -1, e0);
        idle(20);
        checks++; if (vcnt !== v0 + 1 || data !== exp_v) begin errors++; $display("FAIL spike_data got=%h exp=%h", data, exp_v); end
    endtask

    task automatic test_pulse_rules();
        checks++; if (overlap !== 0) begin errors++; $display("FAIL pulse_overlap got=%0d exp=0", overlap); end
        checks++; if (wide !== 0) begin errors++; $display("FAIL pulse_width got=%0d exp=0", wide); end
    endtask

    initial begin
        rst_n = 1'b1;
        rx    = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_majority();
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 80_000_000, system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD_RATE, default 115200, serial bit rate in baud.
REQ-003 SHALL provide port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL provide port i_rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL provide port i_rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL provide port o_data, output, 8, last correctly framed byte.
REQ-007 SHALL provide port o_rx_valid, output, 1, one-cycle pulse: new byte on o_data.
REQ-008 SHALL provide port o_frame_err, output, 1, one-cycle pulse: stop bit sampled low.
REQ-009 SHALL provide port o_rx_busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL provide port o_state_debug, output, 2, current FSM state encoding.

Function
REQ-011 SHALL compute BIT_TIME = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE and HALF = BIT_TIME/2 (integer), giving 694 and 347 at defaults.
REQ-012 SHALL size the bit counter to $clog2(BIT_TIME)+1 bits; the counter never wraps within a bit.
REQ-013 SHALL pass i_rx through a 2-flop synchronizer; the FSM uses only the synchronized signal.
REQ-014 SHALL keep a third register holding the previous synchronized value for falling-edge detection.
REQ-015 SHALL encode states as IDLE=0, START=1, READ_DATA=2, STOP=3.
REQ-016 IDLE: on synchronized falling edge (previous 1, current 0), go to START with counter cleared; a line held low never re-triggers.
REQ-017 START: at counter==HALF-1, sample the line; low -> READ_DATA with counter and bit index cleared; high -> IDLE (glitch reject, no pulse).
REQ-018 READ_DATA: at counter==BIT_TIME-1, sample one bit LSB-first into the shift register; after bit index 7 go to STOP.
REQ-019 STOP: at counter==BIT_TIME-1, sample; high -> o_data <= shift register and o_rx_valid=1 for one cycle; low -> o_frame_err=1 for one cycle, o_data unchanged; both -> IDLE.
REQ-020 SHALL assert o_rx_valid on the edge 3+HALF+9*BIT_TIME cycles after the first edge that registers i_rx low (6596 at defaults).
REQ-021 o_rx_valid and o_frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle.
REQ-022 o_data SHALL hold its value until the next valid frame, independent of errors or glitches.
REQ-023 An unused state encoding SHALL return to IDLE on the next edge.
REQ-024 A new start edge arriving in the same cycle IDLE is re-entered SHALL be detected if the previous sample was high.

Reset
REQ-025 While i_rst_n==0 at a clock edge: state=IDLE, counter=0, bit index=0, shift register=0, o_data=0, o_rx_valid=0, o_frame_err=0, synchronizer and edge registers=1.
REQ-026 Reset mid-frame SHALL abort the frame with no pulse; reception resumes only on a fresh falling edge after release.

Configuration
REQ-027 Macro UART_RX_MAJORITY_EN defined: each sample point (start, data, stop) SHALL use the 2-of-3 majority of the last three synchronized values; timing unchanged.
REQ-028 Macro UART_RX_MAJORITY_EN undefined: each sample point SHALL use the single current synchronized value, and the majority registers SHALL be absent.

Verification
REQ-029 Defaults, send 0xA5 (8N1, 694-cycle bits) -> o_data=0xA5, o_rx_valid pulse 6596 cycles after start edge, o_frame_err=0.
REQ-030 Back-to-back 0x00, 0xFF, 0x5A with no idle gap -> three o_rx_valid pulses, o_data 0x00, 0xFF, 0x5A in order.
REQ-031 Send 0x3C with stop bit low, then line high -> o_frame_err pulse, no o_rx_valid, o_data keeps previous value; next 0x81 is received correctly.
REQ-032 100-cycle low glitch on idle line -> START then IDLE, o_rx_busy returns low, no pulses.
REQ-033 Assert i_rst_n=0 during bit 4 of 0x77 -> all outputs at reset values next edge, no pulse; following 0x12 is received correctly.
REQ-034 With UART_RX_MAJORITY_EN, 1-cycle inverted spike at every data-bit sample point of 0xC3 -> o_data=0xC3; without the macro, the corrupted byte is received.
